// File: rtl/crc_job_master.sv
// Bus initiator that sequences CRC peripheral register writes for one job, streams data, and reads back the result.
// Optional build macro CRC_CHECK_EN adds a compare against a latched expected CRC value.
module crc_job_master #(
  parameter logic [31:0] CRC_BASE  = 32'h4003_2000,
  parameter logic [31:0] IDLE_ADDR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      cfg_ctrl,
  input  logic [31:0]      cfg_poly,
  input  logic [31:0]      cfg_seed,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  input  logic             s_last,
  output logic [31:0]      bus_addr,
  output logic             bus_rw,
  output logic [31:0]      bus_data_wr,
  input  logic [31:0]      bus_data_rd,
  output logic             busy,
  output logic [31:0]      result,
  output logic             result_valid,
`ifdef CRC_CHECK_EN
  input  logic [31:0]      cfg_expected,
  output logic             crc_match,
`endif
  output logic [CNT_W-1:0] word_count
);

  localparam logic [31:0] ADDR_DATA = CRC_BASE;
  localparam logic [31:0] ADDR_POLY = CRC_BASE + 32'h4;
  localparam logic [31:0] ADDR_CTRL = CRC_BASE + 32'h8;
  localparam logic [31:0] WAS_MASK  = 32'h0200_0000;

  typedef enum logic [2:0] {
    IDLE, CFG_WAS, CFG_POLY, CFG_SEED, CFG_RUN, STREAM, RD_REQ, RD_CAP
  } state_t;

  state_t            state_reg, state_next;
  logic [31:0]       bus_addr_reg, bus_addr_next;
  logic              bus_rw_reg, bus_rw_next;
  logic [31:0]       bus_data_reg, bus_data_next;
  logic [31:0]       ctrl_reg, ctrl_next;
  logic [31:0]       poly_reg, poly_next;
  logic [31:0]       seed_reg, seed_next;
  logic [31:0]       result_reg, result_next;
  logic              result_valid_reg, result_valid_next;
  logic [CNT_W-1:0]  word_count_reg, word_count_next;
`ifdef CRC_CHECK_EN
  logic [31:0]       expected_reg, expected_next;
  logic              crc_match_reg, crc_match_next;
`endif

  always_comb begin
    state_next        = state_reg;
    bus_addr_next     = IDLE_ADDR;
    bus_rw_next       = 1'b0;
    bus_data_next     = 32'h0;
    ctrl_next         = ctrl_reg;
    poly_next         = poly_reg;
    seed_next         = seed_reg;
    result_next       = result_reg;
    result_valid_next = 1'b0;
    word_count_next   = word_count_reg;
`ifdef CRC_CHECK_EN
    expected_next     = expected_reg;
    crc_match_next    = crc_match_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next      = CFG_WAS;
          word_count_next = '0;
          ctrl_next       = cfg_ctrl;
          poly_next       = cfg_poly;
          seed_next       = cfg_seed;
`ifdef CRC_CHECK_EN
          expected_next   = cfg_expected;
`endif
          // First write uses the live inputs since the latches update on this same edge.
          bus_addr_next   = ADDR_CTRL;
          bus_rw_next     = 1'b1;
          bus_data_next   = cfg_ctrl | WAS_MASK;
        end
      end
      CFG_WAS: begin
        state_next    = CFG_POLY;
        bus_addr_next = ADDR_POLY;
        bus_rw_next   = 1'b1;
        bus_data_next = poly_reg;
      end
      CFG_POLY: begin
        state_next    = CFG_SEED;
        bus_addr_next = ADDR_DATA;
        bus_rw_next   = 1'b1;
        bus_data_next = seed_reg;
      end
      CFG_SEED: begin
        state_next    = CFG_RUN;
        bus_addr_next = ADDR_CTRL;
        bus_rw_next   = 1'b1;
        bus_data_next = ctrl_reg & ~WAS_MASK;
      end
      CFG_RUN: state_next = STREAM;
      STREAM: begin
        if (s_valid) begin
          bus_addr_next   = ADDR_DATA;
          bus_rw_next     = 1'b1;
          bus_data_next   = s_data;
          word_count_next = (&word_count_reg) ? word_count_reg : word_count_reg + 1'b1;
          if (s_last) state_next = RD_REQ;
        end
      end
      RD_REQ: begin
        state_next    = RD_CAP;
        bus_addr_next = ADDR_DATA;
      end
      RD_CAP: begin
        state_next        = IDLE;
        result_next       = bus_data_rd;
        result_valid_next = 1'b1;
`ifdef CRC_CHECK_EN
        crc_match_next    = (bus_data_rd == expected_reg);
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      bus_addr_reg     <= IDLE_ADDR;
      bus_rw_reg       <= 1'b0;
      bus_data_reg     <= 32'h0;
      ctrl_reg         <= 32'h0;
      poly_reg         <= 32'h0;
      seed_reg         <= 32'h0;
      result_reg       <= 32'h0;
      result_valid_reg <= 1'b0;
      word_count_reg   <= '0;
`ifdef CRC_CHECK_EN
      expected_reg     <= 32'h0;
      crc_match_reg    <= 1'b0;
`endif
    end else begin
      state_reg        <= state_next;
      bus_addr_reg     <= bus_addr_next;
      bus_rw_reg       <= bus_rw_next;
      bus_data_reg     <= bus_data_next;
      ctrl_reg         <= ctrl_next;
      poly_reg         <= poly_next;
      seed_reg         <= seed_next;
      result_reg       <= result_next;
      result_valid_reg <= result_valid_next;
      word_count_reg   <= word_count_next;
`ifdef CRC_CHECK_EN
      expected_reg     <= expected_next;
      crc_match_reg    <= crc_match_next;
`endif
    end
  end

  assign s_ready      = (state_reg == STREAM);
  assign busy         = (state_reg != IDLE);
  assign bus_addr     = bus_addr_reg;
  assign bus_rw       = bus_rw_reg;
  assign bus_data_wr  = bus_data_reg;
  assign result       = result_reg;
  assign result_valid = result_valid_reg;
  assign word_count   = word_count_reg;
`ifdef CRC_CHECK_EN
  assign crc_match    = crc_match_reg;
`endif

endmodule

// File: tb/tb_crc_job_master.sv
// Directed self-checking bench for crc_job_master: config sequence, gapped stream, readback, ignored start, mid-job reset.
module tb_crc_job_master;

  logic        clk = 1'b0;
  logic        rst, start, s_valid, s_ready, s_last, bus_rw, busy, result_valid;
  logic [31:0] cfg_ctrl, cfg_poly, cfg_seed, s_data, bus_addr, bus_data_wr, bus_data_rd, result;
  logic [15:0] word_count;
  logic [31:0] rd_value;
`ifdef CRC_CHECK_EN
  logic [31:0] cfg_expected;
  logic        crc_match;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Minimal peripheral responder: only a read of DATA returns a value.
  assign bus_data_rd = (!bus_rw && bus_addr == 32'h4003_2000) ? rd_value : 32'h0;

  crc_job_master dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_ctrl(cfg_ctrl), .cfg_poly(cfg_poly), .cfg_seed(cfg_seed),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .bus_addr(bus_addr), .bus_rw(bus_rw), .bus_data_wr(bus_data_wr), .bus_data_rd(bus_data_rd),
    .busy(busy), .result(result), .result_valid(result_valid),
`ifdef CRC_CHECK_EN
    .cfg_expected(cfg_expected), .crc_match(crc_match),
`endif
    .word_count(word_count)
  );

  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("  ok %s = %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [64:0] bus_now();
    return {bus_addr, bus_rw, bus_data_wr};
  endfunction

  localparam logic [64:0] BUS_IDLE = {32'h0, 1'b0, 32'h0};

  task automatic do_cfg(input logic [31:0] c, input logic [31:0] p, input logic [31:0] s,
                        input logic [31:0] exp_was, input logic [31:0] exp_run);
    cfg_ctrl = c; cfg_poly = p; cfg_seed = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("cfg_was", bus_now(), {32'h4003_2008, 1'b1, exp_was});
    chk("cfg_wc_clr", 65'(word_count), 65'(0));
    chk("cfg_busy", 65'(busy), 65'(1));
    tick();
    chk("cfg_poly", bus_now(), {32'h4003_2004, 1'b1, p});
    tick();
    chk("cfg_seed", bus_now(), {32'h4003_2000, 1'b1, s});
    tick();
    chk("cfg_run", bus_now(), {32'h4003_2008, 1'b1, exp_run});
    chk("cfg_sready0", 65'(s_ready), 65'(0));
    tick();
    chk("stream_idle", bus_now(), BUS_IDLE);
    chk("stream_sready", 65'(s_ready), 65'(1));
  endtask

  task automatic beat(input logic [31:0] d, input logic last, input int exp_cnt);
    s_valid = 1'b1; s_data = d; s_last = last;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    chk("beat_wr", bus_now(), {32'h4003_2000, 1'b1, d});
    chk("beat_cnt", 65'(word_count), 65'(exp_cnt));
  endtask

  task automatic gap();
    tick();
    chk("gap_idle", bus_now(), BUS_IDLE);
  endtask

  // Called right after the edge that accepted the last beat.
  task automatic do_read(input logic [31:0] v);
    rd_value = v;
    chk("rdreq_sready0", 65'(s_ready), 65'(0));
    chk("rdreq_busy", 65'(busy), 65'(1));
    tick();
    chk("rd_bus", bus_now(), {32'h4003_2000, 1'b0, 32'h0});
    chk("rd_rv_early", 65'(result_valid), 65'(0));
    tick();
    chk("cap_result", 65'(result), 65'(v));
    chk("cap_rv", 65'(result_valid), 65'(1));
    chk("cap_busy", 65'(busy), 65'(0));
    chk("cap_idle", bus_now(), BUS_IDLE);
    tick();
    chk("rv_pulse_end", 65'(result_valid), 65'(0));
    chk("result_held", 65'(result), 65'(v));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 32'h0;
    cfg_ctrl = 32'h0; cfg_poly = 32'h0; cfg_seed = 32'h0; rd_value = 32'h0;
`ifdef CRC_CHECK_EN
    cfg_expected = 32'h0;
`endif
    tick(); tick();
    rst = 1'b0;
    chk("rst_bus", bus_now(), BUS_IDLE);
    chk("rst_sready", 65'(s_ready), 65'(0));
    chk("rst_busy", 65'(busy), 65'(0));
    chk("rst_result", 65'(result), 65'(0));
    chk("rst_rv", 65'(result_valid), 65'(0));
    chk("rst_wc", 65'(word_count), 65'(0));

    // Job 1: config, gapped stream with an ignored start, readback
`ifdef CRC_CHECK_EN
    cfg_expected = 32'hCAFE_F00D;
`endif
    do_cfg(32'h0100_0000, 32'h04C1_1DB7, 32'hFFFF_FFFF, 32'h0300_0000, 32'h0100_0000);
    beat(32'h1111_1111, 1'b0, 1);
    gap();
    beat(32'h2222_2222, 1'b0, 2);
    start = 1'b1; cfg_ctrl = 32'h0000_00FF;
    tick();
    start = 1'b0;
    chk("ign_start_bus", bus_now(), BUS_IDLE);
    chk("ign_start_sready", 65'(s_ready), 65'(1));
    chk("ign_start_wc", 65'(word_count), 65'(2));
    beat(32'h3333_3333, 1'b1, 3);
    do_read(32'hCAFE_F00D);
`ifdef CRC_CHECK_EN
    chk("crc_match_hit", 65'(crc_match), 65'(1));
`endif

    // Job 2: reset after two beats
    do_cfg(32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0200_0000, 32'h0000_0000);
    beat(32'hA5A5_A5A5, 1'b0, 1);
    beat(32'h5A5A_5A5A, 1'b0, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_bus", bus_now(), BUS_IDLE);
    chk("mid_rst_sready", 65'(s_ready), 65'(0));
    chk("mid_rst_busy", 65'(busy), 65'(0));
    chk("mid_rst_wc", 65'(word_count), 65'(0));
    chk("mid_rst_result", 65'(result), 65'(0));

    // Job 3: WAS bit already set in cfg_ctrl must be cleared on the run write
`ifdef CRC_CHECK_EN
    cfg_expected = 32'hCAFE_F00D;
`endif
    do_cfg(32'h0200_0042, 32'h8005_0000, 32'h0000_FFFF, 32'h0200_0042, 32'h0000_0042);
    beat(32'hDEAD_BEEF, 1'b1, 1);
    do_read(32'hCAFE_F00E);
`ifdef CRC_CHECK_EN
    chk("crc_match_miss", 65'(crc_match), 65'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
